ro_pair_sampler: RTL
====================

# ro_pair_sampler

Challenge-driven measurement sequencer for the ring-oscillator PUF. It drives the 3-bit select bus of the 8:1 RO multiplexer and counts rising edges on the multiplexer output. It measures two selected oscillators in turn over a fixed window and emits one response bit: which oscillator is faster. It sits between the challenge source and the multiplexer, taking the place of the scrambler as the select driver and acting as the consumer of `mux_out`.

## Interface
Parameters:
- `WINDOW`, 1024: clock cycles per counting window (≥1).
- `SETTLE`, 4: cycles waited after changing `scr_out` before counting (≥3, covers synchronizer depth).
- `CNT_W`, 16: edge-counter width in bits.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a measurement; sampled in IDLE/DONE only.
- `chal_a`  in  3  index of first oscillator.
- `chal_b`  in  3  index of second oscillator.
- `mux_out`  in  1  selected RO output, asynchronous to `clk`.
- `scr_out`  out  3  multiplexer select.
- `busy`  out  1  measurement in progress.
- `done`  out  1  one-cycle pulse; `resp`/counts valid.
- `resp`  out  1  1 when count A > count B.
- `cnt_a`  out  CNT_W  edge count of oscillator A.
- `cnt_b`  out  CNT_W  edge count of oscillator B.
- `tie`  out  1  counts equal (only with `RO_SAMPLER_TIE_FLAG_EN`).

## Operation
- States: IDLE, SETTLE_A, COUNT_A, SETTLE_B, COUNT_B, DONE.
- IDLE/DONE with `start`=1: latch `chal_a`/`chal_b`, set `scr_out`=chal_a, clear `cnt_a`/`cnt_b`, go to SETTLE_A.
- SETTLE_A: hold for SETTLE cycles, then go to COUNT_A.
- COUNT_A: for WINDOW cycles, increment `cnt_a` on each detected rising edge. Then set `scr_out`=chal_b and go to SETTLE_B.
- SETTLE_B and COUNT_B behave like SETTLE_A and COUNT_A, counting into `cnt_b`. Then go to DONE.
- DONE lasts exactly one cycle, then returns to IDLE unless `start` is asserted.
- Edge detection: `mux_out` passes through a 2-FF synchronizer and a delay FF. A rising edge is synced=1 while the delayed copy is 0. The synchronizer runs in every state, so no spurious edge appears at window start.
- Counters saturate at 2^CNT_W−1; they never wrap.
- `resp` = (cnt_a > cnt_b), unsigned. A tie gives 0.
- `chal_a`==`chal_b` is legal; the block measures the same oscillator twice.
- `start` is ignored in all states other than IDLE and DONE. Challenge inputs are ignored except at acceptance.
- `scr_out`, `cnt_a`, `cnt_b` and `resp` hold their last values after DONE until the next accept.
- Reset values: `scr_out`=0, `busy`=0, `done`=0, `resp`=0, `cnt_a`=0, `cnt_b`=0, `tie`=0. State = IDLE.
- Reset asserted mid-measurement aborts immediately to the reset values. No `done` is produced.

## Timing
- `start` sampled high at edge k: from edge k, `busy`=1 and `scr_out`=chal_a.
- `scr_out`=chal_b from edge k+SETTLE+WINDOW.
- `done`=1 and `busy`=0 from edge k+2·(SETTLE+WINDOW) for one cycle. `resp`, `cnt_a`, `cnt_b` are valid in that cycle.
- Back-to-back: `start` high during the DONE cycle is accepted; `busy` is then high again from the next edge, with no idle gap.
- RO frequency must be below clk/2 for exact counts. Quantisation error is ±1 count per window.

## Configuration
- `RO_SAMPLER_TIE_FLAG_EN` defined: port `tie` exists. It is registered with `resp` and is 1 in and after DONE when cnt_a==cnt_b. It resets to 0.
- Macro undefined: no `tie` port. A tie is indistinguishable from cnt_a<cnt_b (`resp`=0).

## Test plan
Settings: WINDOW=64, SETTLE=4, CNT_W=8. The bench RO model gives index 2 a period of 4 clk and index 5 a period of 8 clk.

- Reset then idle: all outputs 0, `busy`=0, and `done` never pulses without `start`.
- `start` with chal_a=2, chal_b=5: `scr_out`=2, then 5 at k+68. `done` at k+136. `cnt_a`=16±1, `cnt_b`=8±1, `resp`=1.
- chal_a=5, chal_b=2: `resp`=0, `cnt_a`=8±1, `cnt_b`=16±1.
- chal_a=chal_b=2 with the macro defined, and a noise-free RO model with phase aligned to window start: `cnt_a`==`cnt_b`, `resp`=0, `tie`=1.
- Saturation: RO period 2 clk with WINDOW=600 gives `cnt_a`=255, not wrapped.
- Extra `start` pulses during `busy` are ignored. `start` held in the DONE cycle gives a back-to-back run.
- `rst` at k+70 gives all outputs 0 at once, with no `done` pulse.

Source files
------------

// File: rtl/ro_pair_sampler.sv
// Ring-oscillator PUF pair sampler: selects two ROs in turn, counts edges over a window, emits resp.
// Optional RO_SAMPLER_TIE_FLAG_EN adds the registered tie output.
module ro_pair_sampler #(
    parameter int WINDOW = 1024,
    parameter int SETTLE = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       chal_a,
    input  logic [2:0]       chal_b,
    input  logic             mux_out,
    output logic [2:0]       scr_out,
    output logic             busy,
    output logic             done,
    output logic             resp,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`ifdef RO_SAMPLER_TIE_FLAG_EN
    ,
    output logic             tie
`endif
);
    localparam int TW = $clog2(((WINDOW > SETTLE) ? WINDOW : SETTLE) + 1);
    localparam logic [TW-1:0]    SET_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0]    WIN_LAST = TW'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {IDLE, SETTLE_A, COUNT_A, SETTLE_B, COUNT_B, DONE} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d, dly_q, dly_d;
    logic [2:0]       scr_q, scr_d, ch_b_q, ch_b_d;
    logic             busy_q, busy_d, done_q, done_d, resp_q, resp_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic             rise;
`ifdef RO_SAMPLER_TIE_FLAG_EN
    logic             tie_q, tie_d;
`endif

    assign rise = sync2_q & ~dly_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 1'b1;
        sync1_d = mux_out;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        scr_d   = scr_q;
        ch_b_d  = ch_b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        resp_d  = resp_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
`ifdef RO_SAMPLER_TIE_FLAG_EN
        tie_d   = tie_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                tmr_d   = '0;
                state_d = IDLE;
                if (start) begin
                    state_d = SETTLE_A;
                    scr_d   = chal_a;
                    ch_b_d  = chal_b;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    busy_d  = 1'b1;
                end
            end
            SETTLE_A: if (tmr_q == SET_LAST) begin
                state_d = COUNT_A;
                tmr_d   = '0;
            end
            COUNT_A: begin
                if (rise && cnt_a_q != CNT_MAX) cnt_a_d = cnt_a_q + 1'b1;
                if (tmr_q == WIN_LAST) begin
                    state_d = SETTLE_B;
                    scr_d   = ch_b_q;
                    tmr_d   = '0;
                end
            end
            SETTLE_B: if (tmr_q == SET_LAST) begin
                state_d = COUNT_B;
                tmr_d   = '0;
            end
            COUNT_B: begin
                if (rise && cnt_b_q != CNT_MAX) cnt_b_d = cnt_b_q + 1'b1;
                if (tmr_q == WIN_LAST) begin
                    // compare against the final count, including this cycle's edge
                    state_d = DONE;
                    tmr_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    resp_d  = cnt_a_q > cnt_b_d;
`ifdef RO_SAMPLER_TIE_FLAG_EN
                    tie_d   = cnt_a_q == cnt_b_d;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
            scr_q   <= '0;
            ch_b_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= 1'b0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
`ifdef RO_SAMPLER_TIE_FLAG_EN
            tie_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
            scr_q   <= scr_d;
            ch_b_q  <= ch_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            resp_q  <= resp_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
`ifdef RO_SAMPLER_TIE_FLAG_EN
            tie_q   <= tie_d;
`endif
        end
    end

    assign scr_out = scr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign resp    = resp_q;
    assign cnt_a   = cnt_a_q;
    assign cnt_b   = cnt_b_q;
`ifdef RO_SAMPLER_TIE_FLAG_EN
    assign tie     = tie_q;
`endif
endmodule
